// File: rtl/corelet_sequencer.sv
// corelet_sequencer: job sequencer for an 8x8 MAC corelet.
// Runs one weight-stationary (WS) or output-stationary (OS) job per start pulse.
// It issues SRAM reads, then the matching FIFO write and read/execute strobes
// one and two cycles later. It also writes psum rows to pmem.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               launch a job (sampled only while idle)
//   cfg_mode/len/acc    job config, latched at launch
//   o_valid             OFIFO has a readable row
//   inst                corelet instruction bits [7:0]
//   mode                latched cfg_mode
//   output_en           OS result shift-out
//   xmem_*/wmem_*       activation/weight SRAM read port (cen active-low)
//   pmem_addr/pmem_wr   psum SRAM write port
//   busy, done          job in progress / one-cycle completion pulse
// Every output comes straight from a flop. Each output's next value is derived
// from the next state, so it lines up with the state register.
module corelet_sequencer #(
   parameter int unsigned row     = 8,
   parameter int unsigned col     = 8,
   parameter int unsigned addr_bw = 11,
   parameter int unsigned W_BASE  = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               cfg_mode,
   input  logic [7:0]         cfg_len,
   input  logic               cfg_acc,
   input  logic               o_valid,
   output logic [7:0]         inst,
   output logic               mode,
   output logic               output_en,
   output logic [addr_bw-1:0] xmem_addr,
   output logic               xmem_cen,
   output logic [addr_bw-1:0] wmem_addr,
   output logic               wmem_cen,
   output logic [addr_bw-1:0] pmem_addr,
   output logic               pmem_wr,
   output logic               busy,
   output logic               done
);

   localparam int unsigned CntW = 16;

   typedef enum logic [3:0] {
      StIdle, StWsWfill, StWsKload, StWsKgap, StWsExec,
      StDrain, StOsExec, StOsFlush, StOsOut, StDone
   } state_e;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d, exec_last;
   logic               mode_q, mode_d, acc_q, acc_d;
   logic [7:0]         len_q, len_d;
   logic [7:0]         rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
   logic               ex_rd_q, ex_rd_d, ex_wr_q, ex_wr_d;
   logic [7:0]         inst_q, inst_d;
   logic               oen_q, oen_d, pwr_q, pwr_d, busy_q, busy_d, done_q, done_d;
   logic               xcen_q, xcen_d, wcen_q, wcen_d;
   logic [addr_bw-1:0] xaddr_q, xaddr_d, waddr_q, waddr_d, paddr_q, paddr_d;
   logic               ws_out, os_out, kload, x_rd, w_rd, ofifo_rd;

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      len_d     = len_q;
      acc_d     = acc_q;
      exec_last = CntW'(len_q) + CntW'(1);
      unique case (state_q)
         StIdle: begin
            if (start) begin
               mode_d = cfg_mode;
               len_d  = cfg_len;
               acc_d  = cfg_acc;
               if (cfg_len == 8'd0)   state_d = StDone;
               else if (cfg_mode)     state_d = StOsExec;
               else                   state_d = StWsWfill;
            end
         end
         StWsWfill: if (cnt_q == CntW'(col))             state_d = StWsKload;
         StWsKload: if (cnt_q == CntW'(col - 1))         state_d = StWsKgap;
         StWsKgap:  if (cnt_q == CntW'(row + col - 1))   state_d = StWsExec;
         StWsExec:  if (cnt_q == exec_last)              state_d = StDrain;
         // wr_cnt_q already includes this cycle's pmem_wr
         StDrain:   if (wr_cnt_q == len_q)               state_d = StDone;
         StOsExec:  if (cnt_q == exec_last)              state_d = StOsFlush;
         StOsFlush: if (cnt_q == CntW'(row + col - 1))   state_d = StOsOut;
         StOsOut:   if (cnt_q == CntW'(row - 1))         state_d = StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase

      if (state_d != state_q)                            cnt_d = '0;
      else if (state_q == StIdle || state_q == StDrain)  cnt_d = cnt_q;
      else                                               cnt_d = cnt_q + CntW'(1);

      ws_out = (state_d == StWsExec) || (state_d == StDrain);
      os_out = (state_d == StOsOut);
      kload  = (state_d == StWsKload);
      x_rd   = ((state_d == StWsWfill) && (cnt_d < CntW'(col)))
            || (((state_d == StWsExec) || (state_d == StOsExec)) && (cnt_d < CntW'(len_d)));
      w_rd   = (state_d == StOsExec) && (cnt_d < CntW'(len_d));
      // Never pop more OFIFO rows than the job produces
      ofifo_rd = ws_out && o_valid && (rd_cnt_q < len_d);

      xcen_d  = ~x_rd;
      wcen_d  = ~w_rd;
      xaddr_d = xaddr_q;
      if (x_rd) begin
         xaddr_d = (state_d == StWsWfill) ? addr_bw'(W_BASE) + addr_bw'(cnt_d) : addr_bw'(cnt_d);
      end
      waddr_d = w_rd ? addr_bw'(cnt_d) : waddr_q;

      // Weight-fill reads only feed L0; execute strobes come from exec-phase reads
      ex_rd_d = x_rd && (state_d != StWsWfill);
      ex_wr_d = ex_rd_q;

      inst_d = {acc_d && ws_out, ofifo_rd, ~wcen_q, inst_q[5],
                ex_wr_q || kload, ~xcen_q, ex_wr_q, kload};

      pwr_d   = inst_q[6] || os_out;
      paddr_d = paddr_q;
      if (os_out)         paddr_d = addr_bw'(cnt_d);
      else if (inst_q[6]) paddr_d = addr_bw'(wr_cnt_q);

      rd_cnt_d = (state_d == StIdle) ? '0 : rd_cnt_q + 8'(ofifo_rd);
      wr_cnt_d = (state_d == StIdle) ? '0 : wr_cnt_q + 8'(inst_q[6]);

      oen_d  = os_out;
      busy_d = (state_d != StIdle);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         mode_q   <= 1'b0;
         len_q    <= '0;
         acc_q    <= 1'b0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         ex_rd_q  <= 1'b0;
         ex_wr_q  <= 1'b0;
         inst_q   <= '0;
         oen_q    <= 1'b0;
         pwr_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         xcen_q   <= 1'b1;
         wcen_q   <= 1'b1;
         xaddr_q  <= '0;
         waddr_q  <= '0;
         paddr_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         len_q    <= len_d;
         acc_q    <= acc_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         ex_rd_q  <= ex_rd_d;
         ex_wr_q  <= ex_wr_d;
         inst_q   <= inst_d;
         oen_q    <= oen_d;
         pwr_q    <= pwr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         xcen_q   <= xcen_d;
         wcen_q   <= wcen_d;
         xaddr_q  <= xaddr_d;
         waddr_q  <= waddr_d;
         paddr_q  <= paddr_d;
      end
   end

   assign inst      = inst_q;
   assign mode      = mode_q;
   assign output_en = oen_q;
   assign xmem_addr = xaddr_q;
   assign xmem_cen  = xcen_q;
   assign wmem_addr = waddr_q;
   assign wmem_cen  = wcen_q;
   assign pmem_addr = paddr_q;
   assign pmem_wr   = pwr_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_corelet_sequencer.sv
// Bench for corelet_sequencer.
// The model describes each job as a timeline: t counts cycles from the first
// busy cycle, and expected outputs come from phase offsets. One checking
// process compares every DUT output on each falling edge. Per-job totals are
// also checked against hand-computed constants.
module tb_corelet_sequencer;

   localparam int R  = 8;
   localparam int C  = 8;
   localparam int AW = 11;
   localparam int WB = 1024;
   localparam int E0 = 3 * C + R + 1;  // first WS exec cycle

   logic          clk, reset, start, cfg_mode, cfg_acc, o_valid;
   logic [7:0]    cfg_len, inst;
   logic          mode, output_en, xmem_cen, wmem_cen, pmem_wr, busy, done;
   logic [AW-1:0] xmem_addr, wmem_addr, pmem_addr;

   corelet_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cfg_mode  (cfg_mode),
      .cfg_len   (cfg_len),
      .cfg_acc   (cfg_acc),
      .o_valid   (o_valid),
      .inst      (inst),
      .mode      (mode),
      .output_en (output_en),
      .xmem_addr (xmem_addr),
      .xmem_cen  (xmem_cen),
      .wmem_addr (wmem_addr),
      .wmem_cen  (wmem_cen),
      .pmem_addr (pmem_addr),
      .pmem_wr   (pmem_wr),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   bit            job, m_mode, m_acc, m_prev6, m_fin, model_ok, i6;
   int            t, te, to, m_len, m_rd, m_wr;
   logic [7:0]    e_inst;
   logic          e_oen, e_xcen, e_wcen, e_pwr, e_busy, e_done, e_mode;
   logic [AW-1:0] e_xaddr, e_waddr, e_paddr;

   initial begin
      job = 0; model_ok = 0; m_mode = 0; m_acc = 0; m_prev6 = 0; m_fin = 0;
      t = 0; m_len = 0; m_rd = 0; m_wr = 0;
      e_xaddr = '0; e_waddr = '0; e_paddr = '0;
      forever begin
         @(posedge clk);
         if (reset) begin
            job = 0; m_mode = 0; m_prev6 = 0; model_ok = 1;
            e_xaddr = '0; e_waddr = '0; e_paddr = '0;
         end else if (!job) begin
            if (start) begin
               job = 1; t = 0; m_mode = cfg_mode; m_len = int'(cfg_len); m_acc = cfg_acc;
               m_rd = 0; m_wr = 0; m_prev6 = 0;
            end
         end else if (m_fin) begin
            job = 0;
         end else begin
            t++;
         end

         e_inst = '0; e_oen = 0; e_xcen = 1; e_wcen = 1; e_pwr = 0;
         e_busy = job; e_mode = m_mode; m_fin = 0; i6 = 0;
         if (job) begin
            if (m_len == 0) begin
               m_fin = (t == 0);
            end else if (m_mode) begin
               m_fin = (t == m_len + 2 + 2 * R + C);
               if (t < m_len) begin
                  e_xcen = 0; e_wcen = 0; e_xaddr = AW'(t); e_waddr = AW'(t);
               end
               if (t >= 1 && t <= m_len) begin e_inst[2] = 1; e_inst[5] = 1; end
               if (t >= 2 && t <= m_len + 1) begin
                  e_inst[4] = 1; e_inst[3] = 1; e_inst[1] = 1;
               end
               to = t - (m_len + 2 + R + C);
               if (to >= 0 && to < R) begin
                  e_oen = 1; e_pwr = 1; e_paddr = AW'(to);
               end
            end else begin
               te = t - E0;
               m_fin = (t >= E0 + m_len + 3) && (m_wr == m_len);
               if (t < C) begin e_xcen = 0; e_xaddr = AW'(WB + t); end
               if (t >= 1 && t <= C) e_inst[2] = 1;
               if (t >= C + 1 && t <= 2 * C) e_inst = 8'h09;
               if (te >= 0 && te < m_len) begin e_xcen = 0; e_xaddr = AW'(te); end
               if (te >= 1 && te <= m_len) e_inst[2] = 1;
               if (te >= 2 && te <= m_len + 1) begin e_inst[3] = 1; e_inst[1] = 1; end
               if (!m_fin && te >= 0) begin
                  e_inst[7] = m_acc;
                  i6 = o_valid && (m_rd < m_len);
                  e_inst[6] = i6;
               end
               if (m_prev6) begin e_pwr = 1; e_paddr = AW'(m_wr); end
               m_wr = m_wr + int'(m_prev6);
               m_rd = m_rd + int'(i6);
               m_prev6 = i6;
            end
            e_done = m_fin;
         end else begin
            e_done = 0;
         end
      end
   end

   // ---------------- checking ----------------
   int n_tests = 0, n_fail = 0;
   int c_busy, c_xrd, c_wrd, c_oen, c_pwr, c_done, c_kl, c_ex, c_osx, c_acc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (time %0t)", nm, act, exp_v, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (model_ok) begin
         chk("inst",      32'(inst),      32'(e_inst));
         chk("xmem_addr", 32'(xmem_addr), 32'(e_xaddr));
         chk("xmem_cen",  32'(xmem_cen),  32'(e_xcen));
         chk("wmem_addr", 32'(wmem_addr), 32'(e_waddr));
         chk("wmem_cen",  32'(wmem_cen),  32'(e_wcen));
         chk("pmem_addr", 32'(pmem_addr), 32'(e_paddr));
         chk("pmem_wr",   32'(pmem_wr),   32'(e_pwr));
         chk("output_en", 32'(output_en), 32'(e_oen));
         chk("busy",      32'(busy),      32'(e_busy));
         chk("done",      32'(done),      32'(e_done));
         chk("mode",      32'(mode),      32'(e_mode));
      end
      c_busy += int'(busy);      c_xrd += int'(!xmem_cen);  c_wrd += int'(!wmem_cen);
      c_oen  += int'(output_en); c_pwr += int'(pmem_wr);    c_done += int'(done);
      c_kl   += int'(inst == 8'h09);
      c_ex   += int'(inst[1]);
      c_osx  += int'(inst[4] && inst[3] && inst[1]);
      c_acc  += int'(inst[7]);
   endtask

   task automatic launch(input logic m, input logic [7:0] l, input logic a);
      cfg_mode = m; cfg_len = l; cfg_acc = a; start = 1;
      c_busy = 0; c_xrd = 0; c_wrd = 0; c_oen = 0; c_pwr = 0; c_done = 0;
      c_kl = 0; c_ex = 0; c_osx = 0; c_acc = 0;
      tick();
      start = 0;
   endtask

   task automatic wait_done(input string nm);
      int k;
      k = 0;
      while (!done && k < 300) begin tick(); k++; end
      chk(nm, 32'(done), 32'd1);
      tick();
   endtask

   initial begin
      reset = 1; start = 0; cfg_mode = 0; cfg_len = 0; cfg_acc = 0; o_valid = 0;
      tick(); tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_xcen", 32'(xmem_cen), 32'd1);
      reset = 0;
      tick();

      // WS, K=4, o_valid tied high
      o_valid = 1;
      launch(1'b0, 8'd4, 1'b1);
      chk("ws4_first_addr", 32'(xmem_addr), 32'd1024);
      wait_done("ws4_timeout");
      chk("ws4_busy", 32'(c_busy), 32'd41);
      chk("ws4_xrd",  32'(c_xrd),  32'd12);
      chk("ws4_kl",   32'(c_kl),   32'd8);
      chk("ws4_exec", 32'(c_ex),   32'd4);
      chk("ws4_pwr",  32'(c_pwr),  32'd4);
      chk("ws4_acc",  32'(c_acc),  32'd7);
      chk("ws4_done", 32'(c_done), 32'd1);
      chk("ws4_paddr_hold", 32'(pmem_addr), 32'd3);

      // OS, K=16, with an ignored start and cfg change mid-job
      launch(1'b1, 8'd16, 1'b1);
      repeat (5) tick();
      start = 1; cfg_mode = 0; cfg_len = 8'd5; cfg_acc = 0;
      tick();
      start = 0;
      wait_done("os16_timeout");
      chk("os16_busy", 32'(c_busy), 32'd43);
      chk("os16_xrd",  32'(c_xrd),  32'd16);
      chk("os16_wrd",  32'(c_wrd),  32'd16);
      chk("os16_exec", 32'(c_osx),  32'd16);
      chk("os16_oen",  32'(c_oen),  32'd8);
      chk("os16_pwr",  32'(c_pwr),  32'd8);
      chk("os16_acc",  32'(c_acc),  32'd0);
      chk("os16_mode", 32'(mode),   32'd1);
      chk("os16_paddr_hold", 32'(pmem_addr), 32'd7);
      chk("os16_xaddr_hold", 32'(xmem_addr), 32'd15);

      // zero-length job
      launch(1'b0, 8'd0, 1'b0);
      wait_done("len0_timeout");
      chk("len0_busy", 32'(c_busy), 32'd1);
      chk("len0_done", 32'(c_done), 32'd1);
      chk("len0_xrd",  32'(c_xrd),  32'd0);
      chk("len0_wrd",  32'(c_wrd),  32'd0);

      // WS, K=3, OFIFO empty until 20 cycles into drain
      o_valid = 0;
      launch(1'b0, 8'd3, 1'b0);
      repeat (58) tick();
      chk("drain_stall_pwr",  32'(c_pwr), 32'd0);
      chk("drain_stall_busy", 32'(busy),  32'd1);
      o_valid = 1;
      wait_done("drain_timeout");
      chk("drain_pwr",  32'(c_pwr),  32'd3);
      chk("drain_busy", 32'(c_busy), 32'd64);

      // reset in the middle of WS exec, then a fresh OS job
      launch(1'b0, 8'd6, 1'b1);
      repeat (35) tick();
      reset = 1;
      tick();
      chk("mrst_inst",  32'(inst),      32'd0);
      chk("mrst_busy",  32'(busy),      32'd0);
      chk("mrst_xcen",  32'(xmem_cen),  32'd1);
      chk("mrst_xaddr", 32'(xmem_addr), 32'd0);
      chk("mrst_mode",  32'(mode),      32'd0);
      reset = 0;
      tick();
      launch(1'b1, 8'd2, 1'b0);
      wait_done("post_rst_timeout");
      chk("post_rst_busy", 32'(c_busy), 32'd29);
      chk("post_rst_oen",  32'(c_oen),  32'd8);
      chk("post_rst_pwr",  32'(c_pwr),  32'd8);
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/corelet_sequencer.md
CORELET_SEQUENCER -- requirements
Module: corelet_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, with ports named clk and reset.
REQ-002 The block SHALL have these parameters:
- row, 8, MAC array rows / L0 lanes
- col, 8, MAC array columns
- addr_bw, 11, memory address width
- W_BASE, 1024, xmem base address of weight vectors
REQ-003 The block SHALL have these ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  launch job; sampled only in IDLE
- cfg_mode  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS)
- cfg_len  in  8  number of activation vectors (K)
- cfg_acc  in  1  drive inst[7] (SFP accumulate) during output phase
- o_valid  in  1  OFIFO has a readable row
- inst  out  8  corelet instruction: [7] acc, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] kernel load
- mode  out  1  registered cfg_mode
- output_en  out  1  OS result shift-out
- xmem_addr  out  addr_bw  activation/weight SRAM address
- xmem_cen  out  1  xmem chip enable, active-low
- wmem_addr  out  addr_bw  OS weight SRAM address
- wmem_cen  out  1  wmem chip enable, active-low
- pmem_addr  out  addr_bw  psum SRAM write address
- pmem_wr  out  1  psum SRAM write strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

Function
REQ-004 States SHALL be IDLE, WS_WFILL, WS_KLOAD, WS_KGAP, WS_EXEC, DRAIN, OS_EXEC, OS_FLUSH, OS_OUT, DONE; one phase counter is shared and cleared on every state change.
REQ-005 In IDLE with start=1, the block SHALL latch cfg_mode/cfg_len/cfg_acc and go to WS_WFILL (mode 0) or OS_EXEC (mode 1); if cfg_len=0, it SHALL go directly to DONE with no memory access.
REQ-006 start SHALL be ignored outside IDLE; latched config SHALL be stable for the whole job.
REQ-007 SRAM read latency is 1 cycle: each FIFO write strobe (l0_wr, ififo_wr) SHALL be the read-issue (cen low) registered by one cycle, and each FIFO read/execute strobe SHALL be the write strobe registered by one further cycle.
REQ-008 WS_WFILL SHALL last col+1 cycles: issue reads at xmem_addr W_BASE..W_BASE+col-1, then one cycle for the final l0_wr.
REQ-009 WS_KLOAD SHALL last col cycles with inst[3]=1 and inst[0]=1.
REQ-010 WS_KGAP SHALL last row+col cycles with inst=0.
REQ-011 WS_EXEC SHALL last cfg_len+2 cycles:
- reads at xmem_addr 0..cfg_len-1
- l0_wr at read+1
- inst[3] and inst[1] together at read+2
REQ-012 During WS_EXEC and DRAIN, inst[6] SHALL equal o_valid; each such read SHALL produce pmem_wr=1 on the next cycle at pmem_addr = read count (0-based).
REQ-013 During WS_EXEC and DRAIN, inst[7] SHALL equal cfg_acc.
REQ-014 DRAIN SHALL stall indefinitely while o_valid=0 and SHALL exit to DONE the cycle after the cfg_len-th pmem_wr.
REQ-015 OS_EXEC SHALL last cfg_len+2 cycles:
- reads at xmem_addr and wmem_addr 0..cfg_len-1 simultaneously
- l0_wr and ififo_wr at read+1
- inst[3], inst[4] and inst[1] together at read+2
REQ-016 OS_FLUSH SHALL last row+col cycles with inst=0.
REQ-017 OS_OUT SHALL last row cycles with output_en=1 and pmem_wr=1 at pmem_addr 0..row-1; inst[6] and inst[7] SHALL be 0 in OS mode.
REQ-018 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-019 When not reading, xmem_cen and wmem_cen SHALL be 1 and addresses SHALL hold their last value.
REQ-020 All outputs SHALL be registered.
REQ-021 Address arithmetic SHALL be unsigned addr_bw-bit and SHALL wrap modulo 2^addr_bw.

Reset
REQ-022 On reset=1 at a clock edge, in any state including mid-job, the next state SHALL be IDLE and the outputs SHALL be:
- inst=0, output_en=0, pmem_wr=0, busy=0, done=0
- xmem_cen=1, wmem_cen=1
- all addresses 0, mode=0
REQ-023 Any pending pipelined strobes SHALL be discarded on reset.

Verification
REQ-024 The bench SHALL cover these scenarios:
- WS, cfg_len=4, o_valid tied 1 -> reads W_BASE..1031, then 8 kernel-load cycles, 16 gap cycles, activation reads 0..3; pmem_wr at 0..3; done pulses once.
- OS, cfg_len=16 -> 16 parallel xmem/wmem reads; 16 cycles with inst[4]=inst[3]=inst[1]=1; output_en high exactly 8 cycles with pmem_addr 0..7.
- cfg_len=0 -> busy high 1 cycle, done the next cycle, xmem_cen/wmem_cen never low.
- WS, cfg_len=3, o_valid held low 20 cycles in DRAIN -> block stays in DRAIN with pmem_wr=0; the 3 writes complete after o_valid rises.
- Reset asserted mid-WS_EXEC -> next cycle all outputs at reset values; a subsequent start runs a full job correctly.
- start pulsed while busy -> ignored; cfg_len changed mid-job has no effect.
